// File: rtl/lock_scramble_ctrl_if.sv
// Session bus of the lock sequencer: user-side handshake (start/abort,
// digit entry, status) plus the scramble-write / read-back path to the
// 3x5-bit register-file shuffle unit.
// master = environment (user panel + register file), slave = controller.
interface lock_scramble_ctrl_if;
  // user side
  logic       start;
  logic       abort;
  logic [4:0] digit;
  logic       digit_valid;
  logic       ready;
  logic       busy;
  logic       unlock;
  logic       fail;
  logic       locked_out;
  // register-file side
  logic       rf_wr;
  logic [1:0] rf_out_sel;
  logic [1:0] rf_reg_sel;
  logic [4:0] rf_rd0;
  logic [4:0] rf_rd1;
  logic [4:0] rf_rd2;

  modport master (
    output start, abort, digit, digit_valid, rf_rd0, rf_rd1, rf_rd2,
    input  ready, busy, unlock, fail, locked_out, rf_wr, rf_out_sel, rf_reg_sel
  );

  modport slave (
    input  start, abort, digit, digit_valid, rf_rd0, rf_rd1, rf_rd2,
    output ready, busy, unlock, fail, locked_out, rf_wr, rf_out_sel, rf_reg_sel
  );
endinterface

// File: rtl/lock_scramble_ctrl.sv
// Session sequencer for the encoded lock. Each session writes one scramble
// permutation (taken from a rotating schedule) into the register-file
// shuffle unit, collects three user digits, compares them with the
// scrambled read-back and then opens, fails, or enters a timed lockout
// after MAX_FAIL consecutive failures. All outputs are registered.
module lock_scramble_ctrl #(
  parameter int N_STEPS     = 4,
  parameter int MAX_FAIL    = 3,
  parameter int OPEN_CYC    = 8,
  parameter int LOCKOUT_CYC = 16
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [4*N_STEPS-1:0]            sched,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt,
  lock_scramble_ctrl_if.slave             bus
);

  localparam int CNT_W   = $clog2(MAX_FAIL + 1);
  localparam int PTR_W   = (N_STEPS > 1) ? $clog2(N_STEPS) : 1;
  localparam int TMR_MAX = (OPEN_CYC > LOCKOUT_CYC) ? OPEN_CYC : LOCKOUT_CYC;
  localparam int TMR_W   = $clog2(TMR_MAX + 1);

  // Identity permutation {outSel=01, regSel=00}, used in place of illegal entries
  localparam logic [3:0] IDENTITY_SEL = 4'b0100;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    SETTLE,
    ENTRY,
    CHECK,
    OPEN,
    LOCKOUT
  } state_t;

  state_t             state;
  logic [PTR_W-1:0]   ptr;
  logic [CNT_W-1:0]   fail_cnt_q;
  logic [CNT_W-1:0]   fail_inc;
  logic [TMR_W-1:0]   timer;
  logic [1:0]         idx;
  logic [4:0]         d0;
  logic [4:0]         d1;
  logic [4:0]         d2;

  logic               rf_wr_q;
  logic [1:0]         out_sel_q;
  logic [1:0]         reg_sel_q;
  logic               ready_q;
  logic               busy_q;
  logic               unlock_q;
  logic               fail_q;
  logic               locked_q;

  logic [3:0]         raw_entry;
  logic               illegal;
  logic [3:0]         legal_entry;
  logic               match;

  // Pick the schedule entry under the pointer and replace illegal permutations with identity
  always_comb begin
    raw_entry   = sched[{ptr, 2'b00} +: 4];
    illegal     = (raw_entry[3:2] == 2'b00) ? (raw_entry[1:0] == 2'b11) : raw_entry[1];
    legal_entry = illegal ? IDENTITY_SEL : raw_entry;
  end

  assign match    = (d0 == bus.rf_rd0) && (d1 == bus.rf_rd1) && (d2 == bus.rf_rd2);
  assign fail_inc = fail_cnt_q + 1'b1;

  assign bus.rf_wr      = rf_wr_q;
  assign bus.rf_out_sel = out_sel_q;
  assign bus.rf_reg_sel = reg_sel_q;
  assign bus.ready      = ready_q;
  assign bus.busy       = busy_q;
  assign bus.unlock     = unlock_q;
  assign bus.fail       = fail_q;
  assign bus.locked_out = locked_q;
  assign fail_cnt       = fail_cnt_q;

  // Session FSM: state, schedule pointer, digit capture, failure counter, timer and registered outputs
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      ptr        <= '0;
      fail_cnt_q <= '0;
      timer      <= '0;
      idx        <= '0;
      d0         <= '0;
      d1         <= '0;
      d2         <= '0;
      rf_wr_q    <= 1'b0;
      out_sel_q  <= 2'b00;
      reg_sel_q  <= 2'b00;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      unlock_q   <= 1'b0;
      fail_q     <= 1'b0;
      locked_q   <= 1'b0;
    end else begin
      // write strobe and fail are single-cycle pulses
      rf_wr_q <= 1'b0;
      fail_q  <= 1'b0;

      case (state)
        IDLE: begin
          if (bus.start) begin
            state     <= ISSUE;
            busy_q    <= 1'b1;
            rf_wr_q   <= 1'b1;
            out_sel_q <= legal_entry[3:2];
            reg_sel_q <= legal_entry[1:0];
          end
        end

        ISSUE: begin
          state <= SETTLE;
        end

        SETTLE: begin
          state   <= ENTRY;
          idx     <= '0;
          ready_q <= 1'b1;
        end

        ENTRY: begin
          if (bus.abort) begin
            state   <= IDLE;
            idx     <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
          end else if (bus.digit_valid) begin
            case (idx)
              2'd0:    d0 <= bus.digit;
              2'd1:    d1 <= bus.digit;
              default: d2 <= bus.digit;
            endcase
            if (idx == 2'd2) begin
              state   <= CHECK;
              idx     <= '0;
              ready_q <= 1'b0;
            end else begin
              idx <= idx + 2'd1;
            end
          end
        end

        CHECK: begin
          ptr <= (ptr == PTR_W'(N_STEPS - 1)) ? '0 : ptr + 1'b1;
          if (match) begin
            state      <= OPEN;
            fail_cnt_q <= '0;
            unlock_q   <= 1'b1;
            timer      <= TMR_W'(OPEN_CYC - 1);
          end else begin
            fail_q     <= 1'b1;
            fail_cnt_q <= fail_inc;
            if (fail_inc == CNT_W'(MAX_FAIL)) begin
              state    <= LOCKOUT;
              locked_q <= 1'b1;
              timer    <= TMR_W'(LOCKOUT_CYC - 1);
            end else begin
              state  <= IDLE;
              busy_q <= 1'b0;
            end
          end
        end

        OPEN: begin
          if (timer == '0) begin
            state    <= IDLE;
            unlock_q <= 1'b0;
            busy_q   <= 1'b0;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        LOCKOUT: begin
          if (timer == '0) begin
            state      <= IDLE;
            locked_q   <= 1'b0;
            busy_q     <= 1'b0;
            fail_cnt_q <= '0;
          end else begin
            timer <= timer - 1'b1;
          end
        end

        default: begin
          state    <= IDLE;
          ready_q  <= 1'b0;
          busy_q   <= 1'b0;
          unlock_q <= 1'b0;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

endmodule
